// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } pipe_state_e;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, data-memory freezes, plus stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  input  logic                 id_uses_rt_i,
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rt_i,
  input  logic                 branch_taken_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ack_i,
  output logic                 pc_write_o,
  output logic                 ifid_write_o,
  output logic                 ifid_flush_o,
  output logic                 idex_write_o,
  output logic                 idex_flush_o,
  output logic                 exmem_write_o,
  output logic                 exmem_flush_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
  output logic                 timeout_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              memwait;
  logic              loaduse;
  logic              stall_inc;
  logic              flush_inc;

  // Hazard compare and output decode; reset forces every enable/clear low.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_write_o = 1'b1;
    exmem_flush_o = 1'b0;
    flush_inc     = 1'b0;
    state_d       = RUN;

    memwait = dmem_req_i & ~dmem_ack_i;
    loaduse = ex_memread_i && (ex_rt_i != ZERO_REG) &&
              ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    if (!rst_n) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
    end else if (memwait) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
      state_d       = MEM_WAIT;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      flush_inc     = 1'b1;
    end else if (loaduse && (state_q != LU_BUBBLE)) begin
      // A load leaving MEM_WAIT is judged exactly like one seen in RUN.
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
      state_d      = LU_BUBBLE;
    end

    stall_inc = rst_n & ~pc_write_o;
  end

  // State register and consecutive-wait tracking; timeout is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (memwait) begin
        if (wait_cnt_q == WAIT_LAST) begin
          timeout_o <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (CNT_W=3, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f}
  localparam logic [6:0] C_NORM = 7'b1101010;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_FRZ  = 7'b0000000;

  logic             clk_i = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs_i, id_rt_i, ex_rt_i;
  logic             id_uses_rt_i, ex_memread_i, branch_taken_i, dmem_req_i, dmem_ack_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o;
  logic             exmem_write_o, exmem_flush_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_write_o   (idex_write_o),
    .idex_flush_o   (idex_flush_o),
    .exmem_write_o  (exmem_write_o),
    .exmem_flush_o  (exmem_flush_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic [6:0] exp);
    checkOutput(tag, {25'd0, pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                      idex_flush_o, exmem_write_o, exmem_flush_o}, {25'd0, exp});
  endtask

  task automatic checkCounts(input string tag, input int stall, input int flush, input logic tmo);
    checkOutput({tag, ".stall"}, 32'(stall_cnt_o), 32'(stall));
    checkOutput({tag, ".flush"}, 32'(flush_cnt_o), 32'(flush));
    checkOutput({tag, ".timeout"}, 32'(timeout_o), 32'(tmo));
  endtask

  // Inputs: memread, ex_rt, id_rs, id_rt, uses_rt, branch, req, ack
  task automatic applyStimulus(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt, input logic br,
                               input logic req, input logic ack);
    ex_memread_i   = mr;
    ex_rt_i        = ert;
    id_rs_i        = rs;
    id_rt_i        = rt;
    id_uses_rt_i   = urt;
    branch_taken_i = br;
    dmem_req_i     = req;
    dmem_ack_i     = ack;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    $display("[TB] reset state");
    checkCtrl("reset.ctrl", C_FRZ);
    checkCounts("reset", 0, 0, 1'b0);
    doReset();
    checkCtrl("run.idle", C_NORM);

    $display("[TB] load-use on rs");
    applyStimulus(1'b1, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("lu.rs.stall", C_LU);
    tick();
    checkCtrl("lu.bubble.masked", C_NORM);
    checkCounts("lu.rs", 1, 0, 1'b0);
    idle();
    tick();
    checkCtrl("lu.after", C_NORM);
    checkOutput("lu.after.stall", 32'(stall_cnt_o), 32'd1);

    $display("[TB] non-hazards and rt hazard");
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("nohaz.r0", C_NORM);
    applyStimulus(1'b1, 5'd3, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("nohaz.rt_unused", C_NORM);
    applyStimulus(1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("nohaz.not_load", C_NORM);
    applyStimulus(1'b1, 5'd3, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("lu.rt.stall", C_LU);
    tick();
    idle();
    tick();
    checkOutput("lu.rt.stall_cnt", 32'(stall_cnt_o), 32'd2);

    $display("[TB] branch over load-use");
    applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("br.flush", C_BR);
    tick();
    checkCounts("br", 2, 1, 1'b0);
    applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("br.next_is_run", C_LU);
    tick();
    idle();
    tick();
    checkOutput("br.after.stall", 32'(stall_cnt_o), 32'd3);

    $display("[TB] memory wait");
    doReset();
    applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCtrl("mw.priority", C_FRZ);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCtrl("mw.frozen", C_FRZ);
    end
    checkCounts("mw.3", 3, 0, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkCtrl("mw.ack", C_NORM);
    tick();
    checkCounts("mw.resume", 3, 0, 1'b0);

    $display("[TB] memory timeout");
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("tmo.3cyc", 32'(timeout_o), 32'd0);
    tick();
    checkOutput("tmo.4cyc", 32'(timeout_o), 32'd1);
    checkOutput("tmo.stall_sat", 32'(stall_cnt_o), 32'd7);
    applyStimulus(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkCtrl("mw.exit_lu", C_LU);
    tick();
    idle();
    tick();
    checkOutput("tmo.sticky", 32'(timeout_o), 32'd1);

    $display("[TB] reset during memory wait");
    doReset();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkCounts("rmw.pre", 5, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkCtrl("rmw.async.ctrl", C_FRZ);
    checkCounts("rmw.async", 0, 0, 1'b0);
    idle();
    tick();
    rst_n = 1'b1;
    #1;
    checkCtrl("rmw.release", C_NORM);
    tick();
    checkCtrl("rmw.run", C_NORM);
    checkOutput("rmw.stall", 32'(stall_cnt_o), 32'd0);

    $display("[TB] stall counter saturation");
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      if (i == 6) checkOutput("sat.7", 32'(stall_cnt_o), 32'd7);
    end
    checkOutput("sat.9", 32'(stall_cnt_o), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
